imm_gen_pipe: RTL and testbench
===============================

// Module: imm_gen_pipe
// PURPOSE
//   Pipelined, parametrised RISC-V immediate generator for the decode stage.
//   Decodes every base immediate format (I, S, B, U, J) to an XLEN-bit sign-extended value.
//   Carries a caller tag alongside the instruction, with valid/ready handshakes on both sides.
//   A 2-entry skid buffer decouples the fetch side from decode-side backpressure.
// PARAMETERS
//   XLEN      64  output immediate width; legal values 32 or 64
//   TAG_W     8   width of the pass-through tag (e.g. ROB/PC index)
//   SHIFT_BJ  0   0: B/J immediates are imm[12:1] / imm[20:1], unshifted; 1: byte offset with bit0=0
// PORTS
//   clk          in   1      single clock, all state updates on its rising edge
//   rst_n        in   1      synchronous, active-low reset
//   in_valid     in   1      instruction word present on in_instr
//   in_ready     out  1      block can accept in_instr this cycle
//   in_instr     in   32     raw 32-bit instruction
//   in_tag       in   TAG_W  opaque tag, returned unchanged with the result
//   out_valid    out  1      result fields valid
//   out_ready    in   1      consumer accepts result this cycle
//   out_imm      out  XLEN   sign-extended immediate
//   out_fmt      out  3      0=none, 1=I, 2=S, 3=B, 4=U, 5=J
//   out_illegal  out  1      opcode not in the supported set
//   out_tag      out  TAG_W  tag of this result
// BEHAVIOUR
//   Reset (rst_n low at a clk edge): skid buffer emptied.
//     out_valid=0, out_imm=0, out_fmt=0, out_illegal=0, out_tag=0.
//     in_ready is forced 0 while rst_n is low and is 1 on the first cycle after release.
//   Reset mid-operation: all in-flight entries are dropped and no result is emitted for them.
//   Opcode decode on in_instr[6:0]:
//     I-format: 0000011 LOAD, 0010011 OP-IMM, 0011011 OP-IMM-32, 1100111 JALR, 1110011 SYSTEM.
//       imm = sext(i[31:20]).
//     S-format: 0100011. imm = sext({i[31:25], i[11:7]}).
//     B-format: 1100011.
//       SHIFT_BJ=0: imm = sext({i[31], i[7], i[30:25], i[11:8]}).
//       SHIFT_BJ=1: the same field with a 0 appended as bit 0.
//     U-format: 0110111 LUI, 0010111 AUIPC. imm = sext({i[31:12], 12'b0}).
//       With XLEN=64, bits 63:32 are copies of i[31].
//     J-format: 1101111.
//       SHIFT_BJ=0: imm = sext({i[31], i[19:12], i[20], i[30:21]}).
//       SHIFT_BJ=1: the same field with a 0 appended as bit 0.
//     Any other opcode: imm=0, fmt=0, out_illegal=1. The result is still delivered in order.
//     Every sign extension takes its sign from i[31].
//   Handshake and latency:
//     An input transfer occurs when in_valid && in_ready at a clk edge.
//     The result is presented one cycle later: out_valid=1 in the cycle after acceptance.
//     An output transfer occurs when out_valid && out_ready.
//     While out_valid=1 && out_ready=0, all out_* fields hold stable.
//   Skid buffer: 2 entries (output register + skid register); count is 0, 1 or 2.
//     in_ready = (count < 2), taken from a register only; no combinational path from out_ready.
//     Simultaneous input and output transfer: count unchanged; order preserved.
//     When count=2, new input is blocked until a transfer drains an entry.
//     Full throughput (one result per cycle) is sustained while out_ready=1.
//   in_instr and in_tag are sampled only on an input transfer; values on other cycles are ignored.
// TESTING
//   1. LD x1,-8(x2): in_instr=0xFF813083.
//      -> one cycle later out_imm=0xFFFF_FFFF_FFFF_FFF8, fmt=1, illegal=0, tag echoed.
//   2. BEQ x0,x0,-4: in_instr=0xFE000EE3.
//      -> SHIFT_BJ=1: out_imm=0xFFFF_FFFF_FFFF_FFFC.
//      -> SHIFT_BJ=0: out_imm=0xFFFF_FFFF_FFFF_FFFE. fmt=3 in both cases.
//   3. LUI x5,0x12345: in_instr=0x123452B7 -> out_imm=0x0000_0000_1234_5000, fmt=4.
//      LUI x5,0x80000: in_instr=0x800002B7 -> out_imm=0xFFFF_FFFF_8000_0000.
//   4. Backpressure: stream 5 instructions with tags 1..5 while out_ready=0.
//      -> in_ready drops after 2 accepts and outputs hold tag 1.
//      -> raising out_ready drains tags 1..5 in order, with none lost or duplicated.
//   5. in_instr=0x0000007F -> out_illegal=1, out_imm=0, fmt=0, and the following instruction is unaffected.
//   6. Assert rst_n=0 for one cycle with count=2.
//      -> out_valid=0 and all outputs 0 next cycle; in_ready=1 after release; no stale result emitted.

Source files
------------

// File: rtl/imm_gen_pipe_if.sv
// Handshake bundle for imm_gen_pipe: fetch-side instruction stream in,
// decoded immediate stream out. The design uses the slave view.
interface imm_gen_pipe_if #(
    parameter int XLEN  = 64,
    parameter int TAG_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_instr;
    logic [TAG_W-1:0] in_tag;

    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_imm;
    logic [2:0]       out_fmt;
    logic             out_illegal;
    logic [TAG_W-1:0] out_tag;

    modport slave (
        input  in_valid, in_instr, in_tag, out_ready,
        output in_ready, out_valid, out_imm, out_fmt, out_illegal, out_tag
    );

    modport master (
        output in_valid, in_instr, in_tag, out_ready,
        input  in_ready, out_valid, out_imm, out_fmt, out_illegal, out_tag
    );
endinterface

// File: rtl/imm_gen_pipe.sv
// Pipelined RISC-V immediate generator. Each accepted instruction is decoded
// on entry and stored, with its tag, in a 2-entry skid buffer (output
// register + skid register). in_ready comes only from a register, so there
// is no combinational path from out_ready back to the fetch side.
module imm_gen_pipe #(
    parameter int XLEN     = 64,
    parameter int TAG_W    = 8,
    parameter int SHIFT_BJ = 0
) (
    input  logic           clk,
    input  logic           rst_n,
    imm_gen_pipe_if.slave  bus
);

    typedef enum logic [2:0] {
        FMT_NONE = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5
    } fmt_e;

    typedef struct packed {
        logic [XLEN-1:0]  imm;
        fmt_e             fmt;
        logic             illegal;
        logic [TAG_W-1:0] tag;
    } entry_t;

    localparam logic [6:0] OP_LOAD      = 7'b0000011;
    localparam logic [6:0] OP_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OP_JALR      = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM    = 7'b1110011;
    localparam logic [6:0] OP_STORE     = 7'b0100011;
    localparam logic [6:0] OP_BRANCH    = 7'b1100011;
    localparam logic [6:0] OP_LUI       = 7'b0110111;
    localparam logic [6:0] OP_AUIPC     = 7'b0010111;
    localparam logic [6:0] OP_JAL       = 7'b1101111;

    // Decode one instruction into a buffer entry. The immediate is first
    // built sign-extended to 32 bits from i[31], then widened to XLEN by a
    // signed cast, which keeps i[31] as the sign for XLEN=64 too.
    function automatic entry_t decode(input logic [31:0] i, input logic [TAG_W-1:0] tag);
        entry_t      e;
        logic [31:0] imm32;
        imm32     = '0;
        e.fmt     = FMT_NONE;
        e.illegal = 1'b0;
        e.tag     = tag;
        case (i[6:0])
            OP_LOAD, OP_OP_IMM, OP_OP_IMM_32, OP_JALR, OP_SYSTEM: begin
                imm32 = {{20{i[31]}}, i[31:20]};
                e.fmt = FMT_I;
            end
            OP_STORE: begin
                imm32 = {{20{i[31]}}, i[31:25], i[11:7]};
                e.fmt = FMT_S;
            end
            OP_BRANCH: begin
                if (SHIFT_BJ != 0)
                    imm32 = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
                else
                    imm32 = {{20{i[31]}}, i[31], i[7], i[30:25], i[11:8]};
                e.fmt = FMT_B;
            end
            OP_LUI, OP_AUIPC: begin
                imm32 = {i[31:12], 12'b0};
                e.fmt = FMT_U;
            end
            OP_JAL: begin
                if (SHIFT_BJ != 0)
                    imm32 = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
                else
                    imm32 = {{12{i[31]}}, i[31], i[19:12], i[20], i[30:21]};
                e.fmt = FMT_J;
            end
            default: begin
                e.illegal = 1'b1;
            end
        endcase
        e.imm = XLEN'($signed(imm32));
        return e;
    endfunction

    entry_t out_q,  out_d;
    entry_t skid_q, skid_d;
    logic   out_valid_q,  out_valid_d;
    logic   skid_valid_q, skid_valid_d;
    logic   in_ready_q,   in_ready_d;

    logic   in_ready;
    logic   in_fire;
    logic   out_fire;
    entry_t new_entry;

    // Ready is registered; reset only masks it while rst_n is held low.
    assign in_ready  = in_ready_q & rst_n;
    assign in_fire   = bus.in_valid & in_ready;
    assign out_fire  = out_valid_q & bus.out_ready;
    assign new_entry = decode(bus.in_instr, bus.in_tag);

    // Next-state of the skid buffer: the output register refills from the
    // skid entry first (oldest), then from the incoming instruction.
    always_comb begin
        out_d        = out_q;
        skid_d       = skid_q;
        out_valid_d  = out_valid_q;
        skid_valid_d = skid_valid_q;

        if (!out_valid_q || out_fire) begin
            if (skid_valid_q) begin
                out_d       = skid_q;
                out_valid_d = 1'b1;
                if (in_fire) begin
                    skid_d = new_entry;
                end else begin
                    skid_valid_d = 1'b0;
                end
            end else if (in_fire) begin
                out_d       = new_entry;
                out_valid_d = 1'b1;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (in_fire) begin
            // Output stalled: the skid slot is free whenever in_ready is high.
            skid_d       = new_entry;
            skid_valid_d = 1'b1;
        end

        in_ready_d = !(out_valid_d && skid_valid_d);
    end

    // Buffer state registers with synchronous active-low reset.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values; the datapath fields are reset as well because
    // the outputs must read as zero after reset, not just be marked invalid.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_q        <= '0;
            skid_q       <= '0;
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b1;
        end else begin
            out_q        <= out_d;
            skid_q       <= skid_d;
            out_valid_q  <= out_valid_d;
            skid_valid_q <= skid_valid_d;
            in_ready_q   <= in_ready_d;
        end
    end

    assign bus.in_ready    = in_ready;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_imm     = out_q.imm;
    assign bus.out_fmt     = out_q.fmt;
    assign bus.out_illegal = out_q.illegal;
    assign bus.out_tag     = out_q.tag;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe. Two instances share the same input stream:
// dut1 uses byte-offset B/J immediates, dut0 the unshifted form.
module tb_imm_gen_pipe;

    localparam int XLEN  = 64;
    localparam int TAG_W = 8;
    localparam int NV    = 16;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic [31:0]      in_instr;
    logic [TAG_W-1:0] in_tag;
    logic             out_ready;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    imm_gen_pipe_if #(.XLEN(XLEN), .TAG_W(TAG_W)) bus1 ();
    imm_gen_pipe_if #(.XLEN(XLEN), .TAG_W(TAG_W)) bus0 ();

    assign bus1.in_valid  = in_valid;
    assign bus1.in_instr  = in_instr;
    assign bus1.in_tag    = in_tag;
    assign bus1.out_ready = out_ready;
    assign bus0.in_valid  = in_valid;
    assign bus0.in_instr  = in_instr;
    assign bus0.in_tag    = in_tag;
    assign bus0.out_ready = out_ready;

    imm_gen_pipe #(.XLEN(XLEN), .TAG_W(TAG_W), .SHIFT_BJ(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1.slave)
    );

    imm_gen_pipe #(.XLEN(XLEN), .TAG_W(TAG_W), .SHIFT_BJ(0)) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0.slave)
    );

    // Hand-decoded vectors: instruction, imm with SHIFT_BJ=1, imm with SHIFT_BJ=0, fmt, illegal.
    logic [31:0] v_instr [NV] = '{
        32'hFF813083, 32'hFE000EE3, 32'h123452B7, 32'h800002B7,
        32'hFE512E23, 32'h0010006F, 32'hFFDFF06F, 32'h7FF00093,
        32'hFFFFF097, 32'h0000007F, 32'h80002073, 32'h0010009B,
        32'h00008067, 32'h00001863, 32'hFFFFFFFF, 32'h00208033};
    logic [63:0] v_imm1 [NV] = '{
        64'hFFFF_FFFF_FFFF_FFF8, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0000_0000_1234_5000, 64'hFFFF_FFFF_8000_0000,
        64'hFFFF_FFFF_FFFF_FFFC, 64'h0000_0000_0000_0800, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0000_0000_0000_07FF,
        64'hFFFF_FFFF_FFFF_F000, 64'h0,                   64'hFFFF_FFFF_FFFF_F800, 64'h0000_0000_0000_0001,
        64'h0,                   64'h0000_0000_0000_0010, 64'h0,                   64'h0};
    logic [63:0] v_imm0 [NV] = '{
        64'hFFFF_FFFF_FFFF_FFF8, 64'hFFFF_FFFF_FFFF_FFFE, 64'h0000_0000_1234_5000, 64'hFFFF_FFFF_8000_0000,
        64'hFFFF_FFFF_FFFF_FFFC, 64'h0000_0000_0000_0400, 64'hFFFF_FFFF_FFFF_FFFE, 64'h0000_0000_0000_07FF,
        64'hFFFF_FFFF_FFFF_F000, 64'h0,                   64'hFFFF_FFFF_FFFF_F800, 64'h0000_0000_0000_0001,
        64'h0,                   64'h0000_0000_0000_0008, 64'h0,                   64'h0};
    logic [2:0] v_fmt [NV] = '{
        3'd1, 3'd3, 3'd4, 3'd4, 3'd2, 3'd5, 3'd5, 3'd1,
        3'd4, 3'd0, 3'd1, 3'd1, 3'd1, 3'd3, 3'd0, 3'd0};
    logic v_ill [NV] = '{
        1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
        1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

    function automatic logic [31:0] lui_for(input int k);
        return (32'(k) << 12) | 32'h0000_02B7;
    endfunction

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_instr  = '0;
        in_tag    = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++;
        if ({bus1.out_valid, bus1.out_imm, bus1.out_fmt, bus1.out_illegal, bus1.out_tag} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got v=%b imm=%h fmt=%0d ill=%b tag=%h, want all zero",
                     bus1.out_valid, bus1.out_imm, bus1.out_fmt, bus1.out_illegal, bus1.out_tag);
        end
        total++;
        if (bus1.in_ready !== 1'b0) begin
            bad++;
            $display("FAIL reset_in_ready_low: got %b want 0", bus1.in_ready);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if (bus1.in_ready !== 1'b1 || bus1.out_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_release: got in_ready=%b out_valid=%b want 1/0",
                     bus1.in_ready, bus1.out_valid);
        end
    endtask

    // One instruction at a time, checking the result one cycle after acceptance.
    task automatic test_formats();
        for (int i = 0; i < NV; i++) begin
            @(posedge clk); #1;
            out_ready = 1'b1;
            in_valid  = 1'b1;
            in_instr  = v_instr[i];
            in_tag    = 8'h10 + 8'(i);
            @(posedge clk); #1;
            in_valid  = 1'b0;
            in_instr  = 32'hDEAD_BEEF;
            @(negedge clk);
            total++;
            if ({bus1.out_valid, bus1.out_imm, bus1.out_fmt, bus1.out_illegal, bus1.out_tag} !==
                {1'b1, v_imm1[i], v_fmt[i], v_ill[i], 8'h10 + 8'(i)}) begin
                bad++;
                $display("FAIL fmt_vec%0d: got v=%b imm=%h fmt=%0d ill=%b tag=%h, want v=1 imm=%h fmt=%0d ill=%b tag=%h",
                         i, bus1.out_valid, bus1.out_imm, bus1.out_fmt, bus1.out_illegal, bus1.out_tag,
                         v_imm1[i], v_fmt[i], v_ill[i], 8'h10 + 8'(i));
            end
            total++;
            if (bus0.out_valid !== 1'b1 || bus0.out_imm !== v_imm0[i] || bus0.out_fmt !== v_fmt[i]) begin
                bad++;
                $display("FAIL unshifted_vec%0d: got v=%b imm=%h fmt=%0d, want v=1 imm=%h fmt=%0d",
                         i, bus0.out_valid, bus0.out_imm, bus0.out_fmt, v_imm0[i], v_fmt[i]);
            end
        end
        @(posedge clk); #1;
    endtask

    // Full-rate stream with out_ready held high: one result per cycle, in order,
    // including an illegal opcode followed directly by a legal instruction.
    task automatic test_back_to_back();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_instr  = v_instr[0];
        in_tag    = 8'hA0;
        for (int i = 0; i < NV; i++) begin
            @(posedge clk); #1;
            if (i + 1 < NV) begin
                in_instr = v_instr[i + 1];
                in_tag   = 8'hA0 + 8'(i + 1);
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            total++;
            if ({bus1.out_valid, bus1.out_imm, bus1.out_fmt, bus1.out_illegal, bus1.out_tag} !==
                {1'b1, v_imm1[i], v_fmt[i], v_ill[i], 8'hA0 + 8'(i)} || bus1.in_ready !== 1'b1) begin
                bad++;
                $display("FAIL b2b_vec%0d: got v=%b imm=%h fmt=%0d ill=%b tag=%h rdy=%b, want v=1 imm=%h fmt=%0d ill=%b tag=%h rdy=1",
                         i, bus1.out_valid, bus1.out_imm, bus1.out_fmt, bus1.out_illegal, bus1.out_tag,
                         bus1.in_ready, v_imm1[i], v_fmt[i], v_ill[i], 8'hA0 + 8'(i));
            end
        end
        @(negedge clk);
        total++;
        if (bus1.out_valid !== 1'b0) begin
            bad++;
            $display("FAIL b2b_drained: got out_valid=%b want 0", bus1.out_valid);
        end
    endtask

    // Five tagged LUIs against a stalled consumer, then drain.
    task automatic test_backpressure();
        int sent;
        int exp_tag;
        bit acc;
        @(posedge clk); #1;
        out_ready = 1'b0;
        sent      = 0;
        exp_tag   = 1;
        in_valid  = 1'b1;
        in_tag    = 8'd1;
        in_instr  = lui_for(1);
        for (int cyc = 0; cyc < 5; cyc++) begin
            @(negedge clk);
            acc = bus1.in_ready;
            if (sent == 2) begin
                total++;
                if (bus1.out_valid !== 1'b1 || bus1.out_tag !== 8'd1 || bus1.out_imm !== 64'h1000) begin
                    bad++;
                    $display("FAIL bp_hold_c%0d: got v=%b tag=%h imm=%h, want v=1 tag=01 imm=1000",
                             cyc, bus1.out_valid, bus1.out_tag, bus1.out_imm);
                end
            end
            @(posedge clk); #1;
            if (acc) begin
                sent++;
                in_tag   = 8'(sent + 1);
                in_instr = lui_for(sent + 1);
            end
        end
        @(negedge clk);
        total++;
        if (sent != 2 || bus1.in_ready !== 1'b0) begin
            bad++;
            $display("FAIL bp_full: got accepts=%0d in_ready=%b, want 2 and 0", sent, bus1.in_ready);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 40 && exp_tag <= 5; cyc++) begin
            @(negedge clk);
            acc = bus1.in_ready && in_valid;
            if (bus1.out_valid === 1'b1) begin
                total++;
                if (bus1.out_tag !== 8'(exp_tag) || bus1.out_imm !== 64'(exp_tag) << 12) begin
                    bad++;
                    $display("FAIL bp_drain%0d: got tag=%h imm=%h, want tag=%h imm=%h",
                             exp_tag, bus1.out_tag, bus1.out_imm, 8'(exp_tag), 64'(exp_tag) << 12);
                end
                exp_tag++;
            end
            @(posedge clk); #1;
            if (acc) begin
                sent++;
                if (sent < 5) begin
                    in_tag   = 8'(sent + 1);
                    in_instr = lui_for(sent + 1);
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        in_valid = 1'b0;
        total++;
        if (exp_tag != 6) begin
            bad++;
            $display("FAIL bp_drain_count: got %0d results want 5 (bound expired)", exp_tag - 1);
        end
        @(negedge clk);
        total++;
        if (bus1.out_valid !== 1'b0) begin
            bad++;
            $display("FAIL bp_no_dup: got out_valid=%b tag=%h want 0", bus1.out_valid, bus1.out_tag);
        end
    endtask

    // Reset with both entries occupied: nothing stale may come out afterwards.
    task automatic test_reset_mid();
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = 32'hFF813083;
        in_tag    = 8'h55;
        @(posedge clk); #1;
        in_tag    = 8'h56;
        @(posedge clk); #1;
        in_valid  = 1'b0;
        @(negedge clk);
        total++;
        if (bus1.in_ready !== 1'b0 || bus1.out_tag !== 8'h55) begin
            bad++;
            $display("FAIL mid_full: got in_ready=%b tag=%h want 0 and 55", bus1.in_ready, bus1.out_tag);
        end
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        total++;
        if ({bus1.out_valid, bus1.out_imm, bus1.out_fmt, bus1.out_illegal, bus1.out_tag} !== '0 ||
            bus1.in_ready !== 1'b1) begin
            bad++;
            $display("FAIL mid_reset: got v=%b imm=%h fmt=%0d ill=%b tag=%h rdy=%b, want zeros and rdy=1",
                     bus1.out_valid, bus1.out_imm, bus1.out_fmt, bus1.out_illegal, bus1.out_tag, bus1.in_ready);
        end
        for (int cyc = 0; cyc < 3; cyc++) begin
            @(negedge clk);
            total++;
            if (bus1.out_valid !== 1'b0) begin
                bad++;
                $display("FAIL mid_stale_c%0d: got out_valid=%b tag=%h want 0", cyc, bus1.out_valid, bus1.out_tag);
            end
        end
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_instr = 32'h123452B7;
        in_tag   = 8'h77;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        total++;
        if (bus1.out_valid !== 1'b1 || bus1.out_imm !== 64'h1234_5000 || bus1.out_tag !== 8'h77) begin
            bad++;
            $display("FAIL mid_resume: got v=%b imm=%h tag=%h want 1 12345000 77",
                     bus1.out_valid, bus1.out_imm, bus1.out_tag);
        end
    endtask

    initial begin
        test_reset();
        test_formats();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

endmodule
